sejf_dial_decoder: RTL and testbench

Parametrised next-generation button decoder for the safe (sejf) dial. Converts two raw push-buttons into step events for the dial counter: cnten step pulse, up direction level, dirch direction-change flag. Adds input synchronisation, per-button debounce, hold-to-auto-repeat and simultaneous-press rejection. Sits between the board buttons and the dial/digit counter.

---
 rtl/sejf_dial_decoder_if.sv | 25 ++
 rtl/sejf_dial_decoder.sv | 175 +++++++++++++++++
 tb/tb_sejf_dial_decoder.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sejf_dial_decoder_if.sv
// Button/step signal bundle for the safe dial decoder.
//   leftButton, rightButton : raw push-buttons (1 = pressed), driven by the board side
//   cnten : one-cycle step pulse
//   up    : step direction, 1 = right/up, 0 = left/down
//   dirch : direction changed on this step
//   busy  : a debounced button is pressed
// master = board/counter side, slave = decoder.
interface sejf_dial_decoder_if;
  logic leftButton;
  logic rightButton;
  logic cnten;
  logic up;
  logic dirch;
  logic busy;

  modport master (
    output leftButton, rightButton,
    input  cnten, up, dirch, busy
  );

  modport slave (
    input  leftButton, rightButton,
    output cnten, up, dirch, busy
  );
endinterface

// File: rtl/sejf_dial_decoder.sv
// Safe dial button decoder: synchronises and debounces two raw buttons,
// turns presses into registered step events with hold-to-auto-repeat and
// rejects a simultaneous press of both buttons.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   dial : sejf_dial_decoder_if.slave (leftButton, rightButton in;
//          cnten, up, dirch, busy out)
module sejf_dial_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 5000000,
  parameter int unsigned REPEAT_PERIOD   = 1000000
) (
  input logic                clk,
  input logic                rst,
  sejf_dial_decoder_if.slave dial
);

  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = $clog2(RMAX + 1);
  localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD_L,
    HOLD_R,
    BLOCKED
  } state_t;

  // bit 0 = left, bit 1 = right throughout
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [DW-1:0] dcnt [2];
  logic          dl;
  logic          dr;

  state_t        state;
  state_t        state_nx;
  logic [RW-1:0] rcnt;
  logic [RW-1:0] rcnt_nx;
  logic          rep;
  logic          rep_nx;
  logic          step;
  logic          step_right;
  logic          step_rep;

  logic          cnten_q;
  logic          up_q;
  logic          dirch_q;
  logic          busy_q;
  logic          last_right;

  assign raw = {dial.rightButton, dial.leftButton};
  assign dl  = deb[0];
  assign dr  = deb[1];

  // Two-stage synchroniser followed by a per-button stability counter.
  // The counter runs while the synced level disagrees with the accepted
  // level; once it has reached DEBOUNCE_CYCLES and the disagreement is
  // still present, the accepted level flips.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        dcnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DW'(DEBOUNCE_CYCLES)) begin
          deb[i]  <= ~deb[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rcnt  <= '0;
      rep   <= 1'b0;
    end else begin
      state <= state_nx;
      rcnt  <= rcnt_nx;
      rep   <= rep_nx;
    end
  end

  // The repeat counter is 0 in the cycle the first step is decided and
  // counts hold cycles from there; it reloads to 1 on every repeat step so
  // that the compare target alone selects delay (first) or period (later).
  always_comb begin
    state_nx   = state;
    rcnt_nx    = '0;
    rep_nx     = 1'b0;
    step       = 1'b0;
    step_right = 1'b0;
    step_rep   = 1'b0;
    unique case (state)
      IDLE: begin
        if (dl && dr) begin
          state_nx = BLOCKED;
        end else if (dl) begin
          step     = 1'b1;
          state_nx = HOLD_L;
          rcnt_nx  = RW'(1);
        end else if (dr) begin
          step       = 1'b1;
          step_right = 1'b1;
          state_nx   = HOLD_R;
          rcnt_nx    = RW'(1);
        end
      end
      HOLD_L, HOLD_R: begin
        step_right = (state == HOLD_R);
        if (!((state == HOLD_L) ? dl : dr)) begin
          state_nx = IDLE;
        end else if (REPEAT_DELAY == 0) begin
          rcnt_nx = '0;
        end else if (rcnt == (rep ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY))) begin
          step     = 1'b1;
          step_rep = 1'b1;
          rcnt_nx  = RW'(1);
          rep_nx   = 1'b1;
        end else begin
          rcnt_nx = rcnt + RW'(1);
          rep_nx  = rep;
        end
      end
      BLOCKED: begin
        if (!dl && !dr) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // last_right starts at left so the first right step flags a change while
  // the first left step does not, even though up resets to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnten_q    <= 1'b0;
      up_q       <= 1'b1;
      dirch_q    <= 1'b0;
      busy_q     <= 1'b0;
      last_right <= 1'b0;
    end else begin
      cnten_q <= step;
      busy_q  <= dl | dr;
      dirch_q <= 1'b0;
      if (step) begin
        up_q       <= step_right;
        dirch_q    <= !step_rep && (step_right != last_right);
        last_right <= step_right;
      end
    end
  end

  assign dial.cnten = cnten_q;
  assign dial.up    = up_q;
  assign dial.dirch = dirch_q;
  assign dial.busy  = busy_q;

endmodule

// File: tb/tb_sejf_dial_decoder.sv
// Bench for sejf_dial_decoder: directed scenarios plus random button
// traffic, compared against a behavioural model through a scoreboard.
module tb_sejf_dial_decoder;
  localparam int DEB = 4;
  localparam int DLY = 20;
  localparam int PER = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sejf_dial_decoder_if dif ();

  sejf_dial_decoder #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(DLY),
    .REPEAT_PERIOD(PER)
  ) dut (
    .clk (clk),
    .rst (rst),
    .dial(dif.slave)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int   edge_n;
    logic up;
    logic dirch;
  } step_t;

  typedef struct {
    logic busy;
    logic up;
  } stat_t;

  step_t step_q[$];
  stat_t stat_q[$];
  int    seen[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Raw samples per clock edge; a reset edge records 0 because the
  // synchroniser is cleared.
  logic  hl[$];
  logic  hr[$];
  int    medge = 0;
  logic  m_dl = 1'b0;
  logic  m_dr = 1'b0;
  string mode = "idle";
  int    age = 0;
  logic  m_last = 1'b0;
  logic  m_up = 1'b1;

  // True when the last DEB+1 samples reaching the debouncer (two edges of
  // synchroniser delay) all equal val.
  function automatic logic settled(input int b, input logic val);
    int   idx;
    logic s;
    for (int k = 0; k <= DEB; k++) begin
      idx = medge - 2 - k;
      s = (idx < 0) ? 1'b0 : (b == 1 ? hr[idx] : hl[idx]);
      if (s != val) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic emit(input logic right, input logic repeat_step);
    step_t sp;
    sp.edge_n = medge;
    sp.up     = right;
    sp.dirch  = repeat_step ? 1'b0 : (right != m_last);
    m_last    = right;
    m_up      = right;
    step_q.push_back(sp);
  endtask

  // Called just after each rising edge with the inputs that edge sampled.
  task automatic model_edge(input logic l, input logic r, input logic rs);
    stat_t st;
    logic  own;
    if (rs) begin
      hl.push_back(1'b0);
      hr.push_back(1'b0);
      m_dl = 1'b0; m_dr = 1'b0; mode = "idle"; age = 0; m_last = 1'b0; m_up = 1'b1;
      st.busy = 1'b0;
      st.up   = 1'b1;
      stat_q.push_back(st);
      medge++;
      return;
    end
    hl.push_back(l);
    hr.push_back(r);
    st.busy = m_dl | m_dr;
    if (mode == "idle") begin
      if (m_dl && m_dr) mode = "blocked";
      else if (m_dl) begin emit(1'b0, 1'b0); mode = "left";  age = 0; end
      else if (m_dr) begin emit(1'b1, 1'b0); mode = "right"; age = 0; end
    end else if (mode == "left" || mode == "right") begin
      own = (mode == "left") ? m_dl : m_dr;
      if (!own) mode = "idle";
      else begin
        age++;
        if (DLY > 0 && age >= DLY && (age - DLY) % PER == 0) emit(mode == "right", 1'b1);
      end
    end else if (!m_dl && !m_dr) begin
      mode = "idle";
    end
    st.up = m_up;
    stat_q.push_back(st);
    if (settled(0, !m_dl)) m_dl = !m_dl;
    if (settled(1, !m_dr)) m_dr = !m_dr;
    medge++;
  endtask

  // ---------------- monitor ----------------
  int    mcyc = 0;
  stat_t mon_st;
  step_t mon_sp;
  logic  exp_step;

  always begin
    @(posedge clk);
    #1;
    if (stat_q.size() > 0) begin
      mon_st = stat_q.pop_front();
      chk("busy", 32'(dif.busy), 32'(mon_st.busy));
      chk("up_level", 32'(dif.up), 32'(mon_st.up));
    end
    exp_step = (step_q.size() > 0) && (step_q[0].edge_n == mcyc);
    if (dif.cnten || exp_step) begin
      chk("cnten", 32'(dif.cnten), 32'(exp_step));
      if (dif.cnten) seen.push_back(mcyc);
      if (exp_step) begin
        mon_sp = step_q.pop_front();
        if (dif.cnten) begin
          chk("step_up", 32'(dif.up), 32'(mon_sp.up));
          chk("step_dirch", 32'(dif.dirch), 32'(mon_sp.dirch));
        end
      end
    end
    mcyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic l, input logic r, input logic rs);
    dif.leftButton  = l;
    dif.rightButton = r;
    rst             = rs;
    @(posedge clk);
    model_edge(l, r, rs);
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cnten"}, 32'(dif.cnten), 0);
    chk({tag, "_dirch"}, 32'(dif.dirch), 0);
    chk({tag, "_busy"},  32'(dif.busy),  0);
    chk({tag, "_up"},    32'(dif.up),    1);
  endtask

  function automatic int nth_seen(input int from, input int n);
    int c = 0;
    foreach (seen[i]) begin
      if (seen[i] >= from) begin
        if (c == n) return seen[i];
        c++;
      end
    end
    return -1;
  endfunction

  function automatic int count_seen(input int lo, input int hi);
    int c = 0;
    foreach (seen[i]) if (seen[i] >= lo && seen[i] < hi) c++;
    return c;
  endfunction

  int   t0;
  int   n;
  logic rl;
  logic rr;

  initial begin
    dif.leftButton  = 1'b0;
    dif.rightButton = 1'b0;
    rst             = 1'b1;
    #1;
    chk_reset_outputs("reset");
    repeat (3) tick(1'b0, 1'b0, 1'b1);
    repeat (5) tick(1'b0, 1'b0, 1'b0);

    // clean right press with auto-repeat
    t0 = medge;
    repeat (40) tick(1'b0, 1'b1, 1'b0);
    repeat (30) tick(1'b0, 1'b0, 1'b0);
    chk("s1_first_step_edge", nth_seen(t0, 0), t0 + 7);
    chk("s1_repeat1_edge",    nth_seen(t0, 1), t0 + 27);
    chk("s1_repeat2_edge",    nth_seen(t0, 2), t0 + 32);

    // direction changes
    repeat (12) tick(1'b0, 1'b1, 1'b0);
    repeat (15) tick(1'b0, 1'b0, 1'b0);
    repeat (12) tick(1'b1, 1'b0, 1'b0);
    repeat (15) tick(1'b0, 1'b0, 1'b0);
    repeat (12) tick(1'b1, 1'b0, 1'b0);
    repeat (15) tick(1'b0, 1'b0, 1'b0);

    // glitch and bounce train before a stable left press
    t0 = medge;
    repeat (3) tick(1'b1, 1'b0, 1'b0);
    repeat (10) tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick(((i / 2) % 2) == 0, 1'b0, 1'b0);
    repeat (15) tick(1'b1, 1'b0, 1'b0);
    repeat (20) tick(1'b0, 1'b0, 1'b0);
    chk("s3_single_step", count_seen(t0, medge), 1);

    // simultaneous press is rejected, then a normal right press
    t0 = medge;
    repeat (30) tick(1'b1, 1'b1, 1'b0);
    repeat (15) tick(1'b0, 1'b0, 1'b0);
    chk("s4_blocked_no_step", count_seen(t0, medge), 0);
    t0 = medge;
    repeat (12) tick(1'b0, 1'b1, 1'b0);
    repeat (15) tick(1'b0, 1'b0, 1'b0);
    chk("s4_right_after_block", count_seen(t0, medge), 1);

    // overlapping holds: left, right joins, left released
    for (int i = 0; i < 45; i++) tick(i < 15, i >= 10, 1'b0);
    repeat (20) tick(1'b0, 1'b0, 1'b0);

    // reset in the middle of a right auto-repeat hold
    repeat (40) tick(1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midhold_reset");
    repeat (3) tick(1'b0, 1'b1, 1'b1);
    t0 = medge;
    repeat (20) tick(1'b0, 1'b1, 1'b0);
    repeat (15) tick(1'b0, 1'b0, 1'b0);
    chk("s6_first_step_after_reset", nth_seen(t0, 0), t0 + 7);

    // random button traffic with occasional resets
    for (int s = 0; s < 40; s++) begin
      rl = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 30);
      if ($urandom_range(0, 19) == 0) repeat (2) tick(rl, rr, 1'b1);
      repeat (n) tick(rl, rr, 1'b0);
    end
    repeat (40) tick(1'b0, 1'b0, 1'b0);

    #2;
    chk("pending_steps", step_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
